// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction format encoding and the decoded-entry
// record that the decode stage queues toward execute.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    // pc/imm are sized for the widest datapath; narrower builds use the low XLEN bits
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        fmt_e                fmt;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [XLEN_MAX-1:0] imm;
        logic                rd_we;
        logic                illegal;
    } decoded_t;

    function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
        return {{(XLEN_MAX-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational RV32I/RV64I field extractor: classifies the format and builds
// the sign-extended immediate; unused fields of each format are forced to zero.
module instr_field_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output decoded_t        o_dec
);

    fmt_e w_fmt;

    always_comb begin
        w_fmt = FMT_NONE;
        unique case (i_instr[6:0])
            OPC_OP:                               w_fmt = FMT_R;
            OPC_OP_32:                            w_fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM:                           w_fmt = FMT_I;
            OPC_OP_IMM_32:                        w_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            OPC_STORE:                            w_fmt = FMT_S;
            OPC_BRANCH:                           w_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                   w_fmt = FMT_U;
            OPC_JAL:                              w_fmt = FMT_J;
            default:                              w_fmt = FMT_NONE;
        endcase
        if (i_instr[1:0] != 2'b11)
            w_fmt = FMT_NONE;
    end

    always_comb begin
        o_dec              = '0;
        o_dec.pc[XLEN-1:0] = i_pc;
        o_dec.opcode       = i_instr[6:0];
        o_dec.fmt          = w_fmt;
        unique case (w_fmt)
            FMT_R: begin
                o_dec.rd     = i_instr[11:7];
                o_dec.rs1    = i_instr[19:15];
                o_dec.rs2    = i_instr[24:20];
                o_dec.funct3 = i_instr[14:12];
                o_dec.funct7 = i_instr[31:25];
            end
            FMT_I: begin
                o_dec.rd     = i_instr[11:7];
                o_dec.rs1    = i_instr[19:15];
                o_dec.funct3 = i_instr[14:12];
                o_dec.imm    = sext32({{20{i_instr[31]}}, i_instr[31:20]});
            end
            FMT_S: begin
                o_dec.rs1    = i_instr[19:15];
                o_dec.rs2    = i_instr[24:20];
                o_dec.funct3 = i_instr[14:12];
                o_dec.imm    = sext32({{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]});
            end
            FMT_B: begin
                o_dec.rs1    = i_instr[19:15];
                o_dec.rs2    = i_instr[24:20];
                o_dec.funct3 = i_instr[14:12];
                o_dec.imm    = sext32({{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                                       i_instr[11:8], 1'b0});
            end
            FMT_U: begin
                o_dec.rd     = i_instr[11:7];
                o_dec.imm    = sext32({i_instr[31:12], 12'b0});
            end
            FMT_J: begin
                o_dec.rd     = i_instr[11:7];
                o_dec.imm    = sext32({{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                                       i_instr[30:21], 1'b0});
            end
            default: ;
        endcase
        o_dec.rd_we   = (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (o_dec.rd != 5'd0);
        o_dec.illegal = (w_fmt == FMT_NONE);
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decodes each accepted beat and queues the final
// result in a DEPTH-entry FIFO so fetch can run ahead of execute stalls.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_rd_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_FW = $clog2(DEPTH + 1);

    decoded_t          r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_FW-1:0] r_count;
    logic [CNT_W-1:0]  r_ill_cnt;

    decoded_t w_dec, w_head;
    logic     w_push, w_pop;

    instr_field_decode #(.XLEN(XLEN)) u_dec (
        .i_instr (in_instr),
        .i_pc    (in_pc),
        .o_dec   (w_dec)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (r_count < CNT_FW'(DEPTH)) || out_ready;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ill_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_dec;
                if (w_dec.illegal && !(&r_ill_cnt))
                    r_ill_cnt <= r_ill_cnt + 1'b1;
            end
            // Flush empties the queue outright; any same-cycle pop is subsumed by it
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= ptr_inc(r_wptr);
                if (w_pop)  r_rptr <= ptr_inc(r_rptr);
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            end
        end
    end

    assign w_head      = r_mem[r_rptr];
    assign out_pc      = w_head.pc[XLEN-1:0];
    assign out_opcode  = w_head.opcode;
    assign out_fmt     = w_head.fmt;
    assign out_rd      = w_head.rd;
    assign out_rs1     = w_head.rs1;
    assign out_rs2     = w_head.rs2;
    assign out_funct3  = w_head.funct3;
    assign out_funct7  = w_head.funct7;
    assign out_imm     = w_head.imm[XLEN-1:0];
    assign out_rd_we   = w_head.rd_we;
    assign out_illegal = w_head.illegal;
    assign illegal_cnt = r_ill_cnt;

    generate
        if (XLEN < XLEN_MAX) begin : g_narrow
            logic w_unused_hi;
            assign w_unused_hi = ^{w_head.pc[XLEN_MAX-1:XLEN], w_head.imm[XLEN_MAX-1:XLEN]};
        end
    endgenerate

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboarded bench for the decode stage: stimulus pushes expected entries,
// a negedge monitor pops and compares every consumed head entry.
module tb_instr_decode_stage;
    import decode_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    // XLEN=32, DEPTH=2, CNT_W=2 instance
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_fmt, out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_rd_we, out_illegal;
    logic [1:0]  illegal_cnt;

    // XLEN=64 instance
    logic        v64 = 1'b0, r64_in, ov64, or64 = 1'b1;
    logic [31:0] i64 = '0;
    logic [63:0] pc64 = '0, opc64, oimm64;
    logic [6:0]  oop64, of7_64;
    logic [2:0]  ofmt64, of3_64;
    logic [4:0]  ord64, ors1_64, ors2_64;
    logic        owe64, oill64;
    logic [15:0] icnt64;

    instr_decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_fmt(out_fmt), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    instr_decode_stage #(.XLEN(64), .DEPTH(2), .CNT_W(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v64), .in_ready(r64_in), .in_instr(i64), .in_pc(pc64),
        .out_valid(ov64), .out_ready(or64), .out_pc(opc64),
        .out_opcode(oop64), .out_fmt(ofmt64), .out_rd(ord64), .out_rs1(ors1_64),
        .out_rs2(ors2_64), .out_funct3(of3_64), .out_funct7(of7_64),
        .out_imm(oimm64), .out_rd_we(owe64), .out_illegal(oill64),
        .illegal_cnt(icnt64)
    );

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, opc;
        logic [31:0] imm;
        logic        we, ill;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [2:0] fmt,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                input logic we, input logic ill, input logic [6:0] opc);
        exp_t e;
        e.pc = pc; e.fmt = fmt; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3;
        e.f7 = f7; e.imm = imm; e.we = we; e.ill = ill; e.opc = opc;
        return e;
    endfunction

    // Caller drives just after a posedge; returns just after the accepting posedge
    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        int t;
        t = 0;
        in_instr = instr; in_pc = pc; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin t++; @(negedge clk); end
        if (!in_ready) begin
            chk("push_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            q.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    logic        held = 1'b0;
    logic [31:0] held_pc, held_imm;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk("pc", out_pc, e.pc);
                chk("opcode", out_opcode, e.opc);
                chk("fmt", out_fmt, e.fmt);
                chk("rd", out_rd, e.rd);
                chk("rs1", out_rs1, e.rs1);
                chk("rs2", out_rs2, e.rs2);
                chk("funct3", out_funct3, e.f3);
                chk("funct7", out_funct7, e.f7);
                chk("imm", out_imm, e.imm);
                chk("rd_we", out_rd_we, e.we);
                chk("illegal", out_illegal, e.ill);
            end
        end
        if (rst_n && out_valid && !out_ready) begin
            if (held) begin
                chk("stall_pc_stable", out_pc, held_pc);
                chk("stall_imm_stable", out_imm, held_imm);
            end
            held = 1'b1; held_pc = out_pc; held_imm = out_imm;
        end else held = 1'b0;
    end

    initial begin
        exp_t ea, ill;
        int t;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_illegal_cnt", illegal_cnt, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_rd_we", out_rd_we, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // RV64 LUI: upper word copies bit 31
        i64 = 32'h800002B7; pc64 = 64'h0000_0001_0000_0040; v64 = 1'b1;
        @(posedge clk); #1; v64 = 1'b0;
        chk("x64_valid", ov64, 1);
        chk("x64_imm", oimm64, 64'hFFFF_FFFF_8000_0000);
        chk("x64_fmt", ofmt64, FMT_U);
        chk("x64_rd", ord64, 5);
        chk("x64_pc", opc64, 64'h0000_0001_0000_0040);

        out_ready = 1'b1;
        push(32'hFFF00093, 32'h100, mk(32'h100, FMT_I, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 7'h13));
        chk("latency_1cycle", out_valid, 1);
        push(32'h0020A423, 32'h104, mk(32'h104, FMT_S, 0, 1, 2, 2, 0, 32'd8, 0, 0, 7'h23));
        push(32'hFE000EE3, 32'h108, mk(32'h108, FMT_B, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 7'h63));
        push(32'h123452B7, 32'h10C, mk(32'h10C, FMT_U, 5, 0, 0, 0, 0, 32'h12345000, 1, 0, 7'h37));
        push(32'h402081B3, 32'h110, mk(32'h110, FMT_R, 3, 1, 2, 0, 7'h20, 0, 1, 0, 7'h33));
        push(32'h008000EF, 32'h114, mk(32'h114, FMT_J, 1, 0, 0, 0, 0, 32'd8, 1, 0, 7'h6F));
        repeat (3) @(posedge clk); #1;

        // Backpressure: fill, see in_ready drop, then release
        out_ready = 1'b0;
        ea = mk(32'h200, FMT_I, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 7'h13);
        push(32'hFFF00093, 32'h200, ea);
        ea.pc = 32'h204; push(32'hFFF00093, 32'h204, ea);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_head_pc", out_pc, 32'h200);
        @(posedge clk); #1;
        ea.pc = 32'h208;
        fork
            push(32'hFFF00093, 32'h208, ea);
            begin repeat (3) @(posedge clk); #1; out_ready = 1'b1; end
        join
        repeat (4) @(posedge clk); #1;

        // Illegal entries and saturating counter (CNT_W=2)
        ill = mk(32'h300, FMT_NONE, 0, 0, 0, 0, 0, 0, 0, 1, 7'h7F);
        push(32'h0000007F, 32'h300, ill);
        chk("ill_cnt_1", illegal_cnt, 1);
        ill.pc = 32'h304; push(32'h0000007F, 32'h304, ill);
        ill.pc = 32'h308; push(32'h0000007F, 32'h308, ill);
        chk("ill_cnt_3", illegal_cnt, 3);
        ill.pc = 32'h30C; push(32'h0000007F, 32'h30C, ill);
        chk("ill_cnt_sat", illegal_cnt, 3);
        push(32'h002081BB, 32'h310, mk(32'h310, FMT_NONE, 0, 0, 0, 0, 0, 0, 0, 1, 7'h3B));
        repeat (3) @(posedge clk); #1;

        // Flush a full FIFO with a beat presented in the same cycle
        out_ready = 1'b0;
        push(32'h0020A423, 32'h500, mk(32'h500, FMT_S, 0, 1, 2, 2, 0, 32'd8, 0, 0, 7'h23));
        push(32'hFE000EE3, 32'h504, mk(32'h504, FMT_B, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 7'h63));
        in_instr = 32'h123452B7; in_pc = 32'h508; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_ill_cnt", illegal_cnt, 3);
        out_ready = 1'b1;
        push(32'h008000EF, 32'h600, mk(32'h600, FMT_J, 1, 0, 0, 0, 0, 32'd8, 1, 0, 7'h6F));
        repeat (3) @(posedge clk); #1;
        chk("post_flush_empty", out_valid, 0);

        // Asynchronous reset between clock edges
        out_ready = 1'b0;
        push(32'hFFF00093, 32'h700, mk(32'h700, FMT_I, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 7'h13));
        #2; rst_n = 1'b0; #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_cnt", illegal_cnt, 0);
        chk("async_rst_pc", out_pc, 0);
        q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(32'h123452B7, 32'h800, mk(32'h800, FMT_U, 5, 0, 0, 0, 0, 32'h12345000, 1, 0, 7'h37));

        t = 0;
        while (q.size() != 0 && t < 20) begin t++; @(negedge clk); end
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
